// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state type and helpers for the UART receiver
// Contents: parity mode codes, receiver FSM state enum, default bit period for
// a 3.125 MHz clock at 230,400 bps, and a 3-input majority helper.

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 3,125,000 / 230,400 = 13.56, rounded to 14 clocks per bit
  localparam int CLKS_PER_BIT_3125K_230K4 = 14;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 2-FF synchroniser plus 3-sample majority vote
// Ports:
//   clk_i  : receiver clock
//   rst_i  : synchronous active-high reset
//   rx_i   : asynchronous serial line, idle high
//   rx_s_o : synchronised line level
//   v_o    : majority of the last three synchronised samples

module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic v_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic [2:0] hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[1:0], sync2_q};
    end
  end

  assign rx_s_o = sync2_q;
  assign v_o    = maj3(hist_q);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with voting and error flags
// Ports:
//   clk_3125    : sole clock
//   rst         : synchronous active-high reset
//   rx          : asynchronous serial line, idle high
//   rx_msg      : last received word (ERR_CHAR on parity error when ERR_SUBST)
//   rx_parity   : received parity bit, 0 when parity is disabled
//   parity_err  : parity mismatch in the last frame
//   frame_err   : a stop bit of the last frame sampled low
//   rx_complete : one-cycle pulse at frame end
//   busy        : receiver is not idle

module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_3125K_230K4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PAR_EVEN,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1,
  parameter int ERR_SUBST    = 1,
  parameter int ERR_CHAR     = 'h3F
) (
  input  logic                 clk_3125,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_msg,
  output logic                 rx_parity,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_complete,
  output logic                 busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CW-1:0]        CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]        CNT_START  = CW'(H + 1);
  localparam logic [3:0]           DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]           STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [DATA_BITS-1:0] ERR_WORD   = DATA_BITS'(ERR_CHAR);
  localparam logic                 HAS_PARITY = 1'(PARITY_MODE != PAR_NONE);
  localparam logic                 ODD_FLIP   = 1'(PARITY_MODE == PAR_ODD);
  localparam logic                 SUBST      = 1'(ERR_SUBST != 0);

  logic rx_s;
  logic v;

  uart_rx_sampler u_sampler (
    .clk_i  (clk_3125),
    .rst_i  (rst),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .v_o    (v)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 armed_q, armed_d;
  logic [1:0]           settle_q, settle_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic                 xor_q, xor_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_w_q, perr_w_d;
  logic                 ferr_w_q, ferr_w_d;
  logic [DATA_BITS-1:0] rx_msg_q, rx_msg_d;
  logic                 rx_parity_q, rx_parity_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_complete_q, rx_complete_d;

  logic bit_tick;
  logic frame_end;

  assign bit_tick  = (cnt_q == CNT_LAST);
  assign frame_end = (state_q == STOP) && bit_tick && (bit_q == STOP_LAST);

  // State register and all datapath registers
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      armed_q       <= 1'b0;
      settle_q      <= 2'b00;
      word_q        <= '0;
      xor_q         <= 1'b0;
      par_bit_q     <= 1'b0;
      perr_w_q      <= 1'b0;
      ferr_w_q      <= 1'b0;
      rx_msg_q      <= '0;
      rx_parity_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_complete_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      armed_q       <= armed_d;
      settle_q      <= settle_d;
      word_q        <= word_d;
      xor_q         <= xor_d;
      par_bit_q     <= par_bit_d;
      perr_w_q      <= perr_w_d;
      ferr_w_q      <= ferr_w_d;
      rx_msg_q      <= rx_msg_d;
      rx_parity_q   <= rx_parity_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      rx_complete_q <= rx_complete_d;
    end
  end

  // Next-state logic: FSM, bit-period counter, bit index and arming
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    armed_d  = armed_q;
    // The synchroniser powers up high; ignore its reset value for two cycles
    // so a line held low through reset is not mistaken for an idle line.
    settle_d = {settle_q[0], 1'b1};

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_s && settle_q[1]) begin
          armed_d = 1'b1;
        end
        if (!rx_s && armed_q) begin
          state_d = START;
          armed_d = 1'b0;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_START) begin
          cnt_d   = '0;
          state_d = v ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_tick) begin
          cnt_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PARITY ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_tick) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_tick) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
            // A clean frame ends on a high line, so the next start edge can
            // be taken immediately; a framing error waits for a real high.
            armed_d = v & ~ferr_w_q;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Output logic: word assembly, parity/framing checks and frame-end update
  always_comb begin
    word_d        = word_q;
    xor_d         = xor_q;
    par_bit_d     = par_bit_q;
    perr_w_d      = perr_w_q;
    ferr_w_d      = ferr_w_q;
    rx_msg_d      = rx_msg_q;
    rx_parity_d   = rx_parity_q;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    rx_complete_d = 1'b0;

    case (state_q)
      START: begin
        word_d    = '0;
        xor_d     = 1'b0;
        par_bit_d = 1'b0;
        perr_w_d  = 1'b0;
        ferr_w_d  = 1'b0;
      end
      DATA: begin
        if (bit_tick) begin
          if (MSB_FIRST != 0) begin
            word_d = {word_q[DATA_BITS-2:0], v};
          end else begin
            word_d = {v, word_q[DATA_BITS-1:1]};
          end
          xor_d = xor_q ^ v;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_bit_d = v;
          perr_w_d  = v ^ xor_q ^ ODD_FLIP;
        end
      end
      STOP: begin
        if (bit_tick && !v) begin
          ferr_w_d = 1'b1;
        end
      end
      default: begin
      end
    endcase

    if (frame_end) begin
      rx_complete_d = 1'b1;
      rx_msg_d      = (perr_w_q && SUBST) ? ERR_WORD : word_q;
      rx_parity_d   = par_bit_q;
      parity_err_d  = perr_w_q;
      frame_err_d   = ferr_w_q | ~v;
    end
  end

  assign rx_msg      = rx_msg_q;
  assign rx_parity   = rx_parity_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign rx_complete = rx_complete_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param

module tb_uart_rx_param;

  localparam int CPB = 14;
  localparam int H   = 7;
  localparam int L   = 151;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx0;
  logic       rx1;

  logic [7:0] msg0;
  logic       par0, perr0, ferr0, rc0, busy0;
  logic [6:0] msg1;
  logic       par1, perr1, ferr1, rc1, busy1;

  int total = 0;
  int bad   = 0;

  uart_rx_param dut0 (
    .clk_3125    (clk),
    .rst         (rst),
    .rx          (rx0),
    .rx_msg      (msg0),
    .rx_parity   (par0),
    .parity_err  (perr0),
    .frame_err   (ferr0),
    .rx_complete (rc0),
    .busy        (busy0)
  );

  uart_rx_param #(
    .DATA_BITS   (7),
    .PARITY_MODE (2),
    .STOP_BITS   (2),
    .MSB_FIRST   (0)
  ) dut1 (
    .clk_3125    (clk),
    .rst         (rst),
    .rx          (rx1),
    .rx_msg      (msg1),
    .rx_parity   (par1),
    .parity_err  (perr1),
    .frame_err   (ferr1),
    .rx_complete (rc1),
    .busy        (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int which, input logic val);
    if (which == 0) rx0 = val;
    else            rx1 = val;
  endtask

  // Serialises one frame at CPB clocks per bit, recording when rx_complete
  // first rose (edge index counted from the first edge that samples the start
  // bit) and how many cycles it was high.
  task automatic send(input int which, input logic [8:0] data, input int nbits,
                      input bit msb, input int pmode, input int stops,
                      input bit flip_par, input bit stop_low, input bit glitch,
                      input int tail, output int done_at, output int pulses);
    logic b [0:15];
    int   n;
    int   cyc;
    logic p;
    logic rcv;
    n = 0;
    p = 1'b0;
    for (int i = 0; i < nbits; i++) p = p ^ data[i];
    b[n] = 1'b0; n++;
    for (int i = 0; i < nbits; i++) begin
      b[n] = msb ? data[nbits-1-i] : data[i];
      n++;
    end
    if (pmode != 0) begin
      b[n] = p ^ (pmode == 2) ^ flip_par;
      n++;
    end
    for (int i = 0; i < stops; i++) begin
      b[n] = ~stop_low;
      n++;
    end
    done_at = -1;
    pulses  = 0;
    cyc     = 0;
    for (int i = 0; i < n + 1; i++) begin
      for (int c = 0; c < ((i < n) ? CPB : tail); c++) begin
        if (i < n) drive(which, (glitch && c == H) ? ~b[i] : b[i]);
        else       drive(which, ~stop_low);
        tick();
        cyc++;
        rcv = (which == 0) ? rc0 : rc1;
        if (rcv) begin
          pulses++;
          if (done_at < 0) done_at = cyc - 1;
        end
      end
    end
  endtask

  int d, p, cnt_busy, cnt_rc;

  initial begin
    rst = 1'b1;
    rx0 = 1'b0;
    rx1 = 1'b1;
    repeat (3) tick();
    chk("rst_msg", msg0, 8'h00);
    chk("rst_parity", par0, 1'b0);
    chk("rst_perr", perr0, 1'b0);
    chk("rst_ferr", ferr0, 1'b0);
    chk("rst_complete", rc0, 1'b0);
    chk("rst_busy", busy0, 1'b0);

    // Line low across reset release: must not start a frame
    rst = 1'b0;
    cnt_busy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy0) cnt_busy++;
    end
    chk("low_at_release_busy", cnt_busy, 0);
    rx0 = 1'b1;
    repeat (6) tick();

    // Clean 0xA5, even parity
    send(0, 9'hA5, 8, 1, 1, 1, 0, 0, 0, 4, d, p);
    chk("a5_latency", d, L);
    chk("a5_pulses", p, 1);
    chk("a5_msg", msg0, 8'hA5);
    chk("a5_perr", perr0, 1'b0);
    chk("a5_ferr", ferr0, 1'b0);
    chk("a5_parity", par0, 1'b0);
    chk("a5_busy_after", busy0, 1'b0);

    // Parity bit flipped
    send(0, 9'hA5, 8, 1, 1, 1, 1, 0, 0, 4, d, p);
    chk("perr_pulses", p, 1);
    chk("perr_flag", perr0, 1'b1);
    chk("perr_msg", msg0, 8'h3F);
    chk("perr_parity", par0, 1'b1);
    chk("perr_ferr", ferr0, 1'b0);

    // Stop bit low, then line held low (break)
    send(0, 9'hA5, 8, 1, 1, 1, 0, 1, 0, 0, d, p);
    chk("ferr_pulses", p, 1);
    chk("ferr_latency", d, L);
    chk("ferr_flag", ferr0, 1'b1);
    chk("ferr_msg", msg0, 8'hA5);
    chk("ferr_perr", perr0, 1'b0);
    cnt_busy = 0;
    cnt_rc   = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy0) cnt_busy++;
      if (rc0)   cnt_rc++;
    end
    chk("break_busy", cnt_busy, 0);
    chk("break_complete", cnt_rc, 0);
    rx0 = 1'b1;
    repeat (6) tick();
    send(0, 9'h3C, 8, 1, 1, 1, 0, 0, 0, 4, d, p);
    chk("3c_msg", msg0, 8'h3C);
    chk("3c_ferr", ferr0, 1'b0);
    chk("3c_perr", perr0, 1'b0);
    chk("3c_latency", d, L);

    // 5-cycle low glitch on idle line
    cnt_busy = 0;
    cnt_rc   = 0;
    rx0 = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) rx0 = 1'b1;
      tick();
      if (busy0) cnt_busy++;
      if (rc0)   cnt_rc++;
    end
    chk("fs_busy_seen", (cnt_busy > 0), 1'b1);
    chk("fs_busy_end", busy0, 1'b0);
    chk("fs_complete", cnt_rc, 0);
    chk("fs_msg", msg0, 8'h3C);
    chk("fs_ferr", ferr0, 1'b0);

    // 7 data bits, odd parity, 2 stops, LSB first
    send(1, 9'h041, 7, 0, 2, 2, 0, 0, 0, 4, d, p);
    chk("b7_latency", d, L);
    chk("b7_pulses", p, 1);
    chk("b7_msg", msg1, 7'h41);
    chk("b7_perr", perr1, 1'b0);
    chk("b7_parity", par1, 1'b1);
    chk("b7_ferr", ferr1, 1'b0);
    send(1, 9'h041, 7, 0, 2, 2, 1, 0, 0, 4, d, p);
    chk("b7_bad_msg", msg1, 7'h3F);
    chk("b7_bad_perr", perr1, 1'b1);
    chk("b7_bad_parity", par1, 1'b0);

    // Centre glitches, back-to-back frames
    send(0, 9'h5A, 8, 1, 1, 1, 0, 0, 1, 0, d, p);
    chk("g1_msg", msg0, 8'h5A);
    chk("g1_perr", perr0, 1'b0);
    chk("g1_ferr", ferr0, 1'b0);
    chk("g1_latency", d, L);
    send(0, 9'h96, 8, 1, 1, 1, 0, 0, 1, 4, d, p);
    chk("g2_msg", msg0, 8'h96);
    chk("g2_latency", d, L);
    chk("g2_pulses", p, 1);
    chk("g2_ferr", ferr0, 1'b0);

    // Reset in the middle of the data bits
    rx0 = 1'b0;
    repeat (CPB) tick();
    rx0 = 1'b1;
    repeat (CPB) tick();
    rx0 = 1'b0;
    repeat (20) tick();
    chk("mid_busy", busy0, 1'b1);
    rst = 1'b1;
    rx0 = 1'b1;
    tick();
    chk("mid_rst_msg", msg0, 8'h00);
    chk("mid_rst_parity", par0, 1'b0);
    chk("mid_rst_perr", perr0, 1'b0);
    chk("mid_rst_ferr", ferr0, 1'b0);
    chk("mid_rst_complete", rc0, 1'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    rst = 1'b0;
    cnt_rc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rc0) cnt_rc++;
    end
    chk("mid_no_complete", cnt_rc, 0);
    chk("mid_idle", busy0, 1'b0);
    send(0, 9'hC3, 8, 1, 1, 1, 0, 0, 0, 4, d, p);
    chk("c3_msg", msg0, 8'hC3);
    chk("c3_latency", d, L);
    chk("c3_perr", perr0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
